// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - two-master AXI read-channel arbiter with burst-length checking
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [LEN_W-1:0]  s0_arlen,
  input  logic [2:0]        s0_arsize,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  output logic [DATA_W-1:0] s0_rdata,
  output logic              s0_rlast,
  output logic              s0_rvalid,
  input  logic              s0_rready,

  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [LEN_W-1:0]  s1_arlen,
  input  logic [2:0]        s1_arsize,
  input  logic              s1_arvalid,
  output logic              s1_arready,
  output logic [DATA_W-1:0] s1_rdata,
  output logic              s1_rlast,
  output logic              s1_rvalid,
  input  logic              s1_rready,

  output logic [ADDR_W-1:0] m_araddr,
  output logic [LEN_W-1:0]  m_arlen,
  output logic [2:0]        m_arsize,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,

  output logic              busy,
  output logic              len_err
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] ADDR = 2'b01;
  localparam logic [1:0] DATA = 2'b10;

  logic [1:0]     state;
  logic [1:0]     state_nxt;
  logic           gnt;
  logic           last_gnt;
  logic           gnt_sel;
  logic [LEN_W:0] beat_cnt;
  logic           grant_fire;
  logic           ar_hs;
  logic           r_hs;
  logic           cnt_match;

  // Pick the requester: a lone request wins outright, a tie goes to whoever was not served last
  always_comb begin
    gnt_sel = 1'b0;
    if (s0_arvalid && s1_arvalid) begin
      gnt_sel = ~last_gnt;
    end else if (s1_arvalid) begin
      gnt_sel = 1'b1;
    end
  end

  assign grant_fire = (state == IDLE) && (s0_arvalid || s1_arvalid);
  assign ar_hs      = (state == ADDR) && m_arvalid && m_arready;
  assign r_hs       = (state == DATA) && m_rvalid && m_rready;
  assign cnt_match  = (beat_cnt == {1'b0, m_arlen});

  // State register; reset abandons any burst in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: one burst at a time, address phase then data phase until the bus's rlast
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = grant_fire ? ADDR : IDLE;
      ADDR:    state_nxt = ar_hs ? DATA : ADDR;
      DATA:    state_nxt = (r_hs && m_rlast) ? IDLE : DATA;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, forwarded AR fields, beat counting and the sticky length-mismatch flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt       <= 1'b0;
      last_gnt  <= 1'b1;
      beat_cnt  <= '0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arsize  <= '0;
      m_arvalid <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_fire) begin
            gnt       <= gnt_sel;
            m_araddr  <= gnt_sel ? s1_araddr : s0_araddr;
            m_arlen   <= gnt_sel ? s1_arlen  : s0_arlen;
            m_arsize  <= gnt_sel ? s1_arsize : s0_arsize;
            m_arvalid <= 1'b1;
            beat_cnt  <= '0;
          end
        end
        ADDR: begin
          if (ar_hs) begin
            m_arvalid <= 1'b0;
            last_gnt  <= gnt;
          end
        end
        DATA: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + {{LEN_W{1'b0}}, 1'b1};
            // rlast early/late, or the counted length reached without rlast (overrun)
            if (m_rlast ? !cnt_match : cnt_match) begin
              len_err <= 1'b1;
            end
          end
        end
        default: begin
          m_arvalid <= 1'b0;
        end
      endcase
    end
  end

  assign s0_rdata = m_rdata;
  assign s1_rdata = m_rdata;

  // Outputs: route AR accept and R beats only to the granted master, nothing while idle
  always_comb begin
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    s0_rvalid  = 1'b0;
    s1_rvalid  = 1'b0;
    s0_rlast   = 1'b0;
    s1_rlast   = 1'b0;
    m_rready   = 1'b0;
    busy       = (state != IDLE);
    case (state)
      ADDR: begin
        s0_arready = ~gnt & m_arready & m_arvalid;
        s1_arready =  gnt & m_arready & m_arvalid;
      end
      DATA: begin
        m_rready  = gnt ? s1_rready : s0_rready;
        s0_rvalid = ~gnt & m_rvalid;
        s1_rvalid =  gnt & m_rvalid;
        s0_rlast  = ~gnt & m_rlast;
        s1_rlast  =  gnt & m_rlast;
      end
      default: begin
        m_rready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - directed self-checking bench for axi_rd_arbiter
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] s0_araddr = '0, s1_araddr = '0;
  logic [7:0]  s0_arlen = '0, s1_arlen = '0;
  logic [2:0]  s0_arsize = '0, s1_arsize = '0;
  logic        s0_arvalid = 1'b0, s1_arvalid = 1'b0;
  logic        s0_arready, s1_arready;
  logic [31:0] s0_rdata, s1_rdata;
  logic        s0_rlast, s1_rlast, s0_rvalid, s1_rvalid;
  logic        s0_rready = 1'b0, s1_rready = 1'b0;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        m_rlast = 1'b0, m_rvalid = 1'b0;
  logic        m_rready;
  logic        busy, len_err;

  int checks = 0;
  int errors = 0;

  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) dut (
    .clk(clk), .rst(rst),
    .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_rdata(s0_rdata),
    .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_rdata(s1_rdata),
    .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rdata(m_rdata),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .busy(busy), .len_err(len_err)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // Wait (bounded) for m_arvalid; lat = number of extra negedges needed.
  task automatic wait_arvalid(output int lat, output bit to);
    for (lat = 0; lat < 20; lat++) begin
      #1;
      if (m_arvalid === 1'b1) break;
      @(negedge clk);
    end
    to = (lat == 20);
  endtask

  // Play the bus side of one burst, recording what the masters observe.
  task automatic run_burst(input int dly, input int rlast_idx, input bit drop,
                           output int lat, output int g, output logic [31:0] addr,
                           output logic [7:0] len, output logic [2:0] size,
                           output bit ar_after, output int n0, output int n1,
                           output int rl0, output int rl1, output int dbad, output bit to);
    n0 = 0; n1 = 0; rl0 = 0; rl1 = 0; dbad = 0; g = -1; ar_after = 1'b0;
    addr = '0; len = '0; size = '0;
    wait_arvalid(lat, to);
    if (to) return;
    addr = m_araddr; len = m_arlen; size = m_arsize;
    repeat (dly) @(negedge clk);
    m_arready = 1'b1;
    #1;
    if (s0_arready) g = 0;
    else if (s1_arready) g = 1;
    @(negedge clk);
    #1 ar_after = s0_arready | s1_arready;
    m_arready = 1'b0;
    if (drop) begin
      if (g == 0) s0_arvalid = 1'b0;
      else if (g == 1) s1_arvalid = 1'b0;
    end
    for (int b = 0; b <= rlast_idx; b++) begin
      m_rvalid = 1'b1;
      m_rdata  = 32'hA000_0000 + b;
      m_rlast  = (b == rlast_idx);
      s0_rready = 1'b1;
      s1_rready = 1'b1;
      #1;
      if (s0_rvalid) begin n0++; if (s0_rlast) rl0++; if (s0_rdata !== 32'hA000_0000 + b) dbad++; end
      if (s1_rvalid) begin n1++; if (s1_rlast) rl1++; if (s1_rdata !== 32'hA000_0000 + b) dbad++; end
      @(negedge clk);
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  task automatic test_reset;
    s0_arvalid = 1'b1; s1_arvalid = 1'b1; m_rvalid = 1'b1; m_arready = 1'b1;
    s0_rready = 1'b1; s1_rready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL reset_m_arvalid: got %b want 0", m_arvalid); end
    checks++; if (m_araddr !== 32'h0) begin errors++; $display("FAIL reset_m_araddr: got %h want 0", m_araddr); end
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL reset_len_err: got %b want 0", len_err); end
    checks++; if (m_rready !== 1'b0) begin errors++; $display("FAIL reset_m_rready: got %b want 0", m_rready); end
    checks++; if ({s0_arready, s1_arready} !== 2'b00) begin errors++; $display("FAIL reset_arready: got %b want 00", {s0_arready, s1_arready}); end
    checks++; if ({s0_rvalid, s1_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b want 00", {s0_rvalid, s1_rvalid}); end
    s0_arvalid = 1'b0; s1_arvalid = 1'b0; m_rvalid = 1'b0; m_arready = 1'b0;
    s0_rready = 1'b0; s1_rready = 1'b0;
  endtask

  task automatic test_single;
    int lat, g, n0, n1, rl0, rl1, dbad;
    logic [31:0] addr; logic [7:0] len; logic [2:0] size; bit ar_after, to;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    s0_araddr = 32'h1FC0_0040; s0_arlen = 8'd15; s0_arsize = 3'd2; s0_arvalid = 1'b1;
    run_burst(2, 15, 1'b1, lat, g, addr, len, size, ar_after, n0, n1, rl0, rl1, dbad, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL single_timeout: m_arvalid never rose"); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL single_latency: got %0d want 1", lat); end
    checks++; if (addr !== 32'h1FC0_0040) begin errors++; $display("FAIL single_araddr: got %h want 1fc00040", addr); end
    checks++; if (len !== 8'd15) begin errors++; $display("FAIL single_arlen: got %0d want 15", len); end
    checks++; if (size !== 3'd2) begin errors++; $display("FAIL single_arsize: got %0d want 2", size); end
    checks++; if (g !== 0) begin errors++; $display("FAIL single_grant: got %0d want 0", g); end
    checks++; if (ar_after !== 1'b0) begin errors++; $display("FAIL single_arready_pulse: got %b want 0", ar_after); end
    checks++; if (n0 !== 16) begin errors++; $display("FAIL single_s0_beats: got %0d want 16", n0); end
    checks++; if (n1 !== 0) begin errors++; $display("FAIL single_s1_beats: got %0d want 0", n1); end
    checks++; if (rl0 !== 1) begin errors++; $display("FAIL single_rlast: got %0d want 1", rl0); end
    checks++; if (dbad !== 0) begin errors++; $display("FAIL single_rdata: got %0d bad want 0", dbad); end
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got busy %b want 0", busy); end
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL single_len_err: got %b want 0", len_err); end
  endtask

  task automatic test_tie;
    int lat, g, n0, n1, rl0, rl1, dbad;
    logic [31:0] addr; logic [7:0] len; logic [2:0] size; bit ar_after, to;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    s0_araddr = 32'h100; s0_arlen = 8'd15; s0_arsize = 3'd2; s0_arvalid = 1'b1;
    s1_araddr = 32'h200; s1_arlen = 8'd0;  s1_arsize = 3'd2; s1_arvalid = 1'b1;
    run_burst(0, 15, 1'b1, lat, g, addr, len, size, ar_after, n0, n1, rl0, rl1, dbad, to);
    checks++; if (g !== 0) begin errors++; $display("FAIL tie_first_grant: got %0d want 0", g); end
    checks++; if (addr !== 32'h100) begin errors++; $display("FAIL tie_first_addr: got %h want 100", addr); end
    checks++; if (n0 !== 16) begin errors++; $display("FAIL tie_first_beats: got %0d want 16", n0); end
    run_burst(0, 0, 1'b1, lat, g, addr, len, size, ar_after, n0, n1, rl0, rl1, dbad, to);
    checks++; if (lat !== 1) begin errors++; $display("FAIL tie_b2b_latency: got %0d want 1", lat); end
    checks++; if (g !== 1) begin errors++; $display("FAIL tie_second_grant: got %0d want 1", g); end
    checks++; if (addr !== 32'h200) begin errors++; $display("FAIL tie_second_addr: got %h want 200", addr); end
    checks++; if (len !== 8'd0) begin errors++; $display("FAIL tie_second_len: got %0d want 0", len); end
    checks++; if (n1 !== 1 || n0 !== 0) begin errors++; $display("FAIL tie_second_beats: got s0=%0d s1=%0d want 0/1", n0, n1); end
  endtask

  task automatic test_fairness;
    int lat, g, n0, n1, rl0, rl1, dbad;
    logic [31:0] addr; logic [7:0] len; logic [2:0] size; bit ar_after, to;
    int exp_g [4];
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;
    @(negedge clk);
    s0_araddr = 32'h1000; s0_arlen = 8'd1; s0_arvalid = 1'b1;
    s1_araddr = 32'h2000; s1_arlen = 8'd1; s1_arvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_burst(0, 1, 1'b0, lat, g, addr, len, size, ar_after, n0, n1, rl0, rl1, dbad, to);
      checks++; if (g !== exp_g[k]) begin errors++; $display("FAIL fair_grant_%0d: got %0d want %0d", k, g, exp_g[k]); end
    end
    s0_arvalid = 1'b0; s1_arvalid = 1'b0;
  endtask

  task automatic test_backpressure;
    int lat; bit to;
    @(negedge clk);
    s1_araddr = 32'h300; s1_arlen = 8'd0; s1_arvalid = 1'b1;
    wait_arvalid(lat, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL bp_timeout: m_arvalid never rose"); end
    m_arready = 1'b1;
    #1;
    checks++; if (s1_arready !== 1'b1) begin errors++; $display("FAIL bp_arready: got %b want 1", s1_arready); end
    @(negedge clk);
    m_arready = 1'b0; s1_arvalid = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF; m_rlast = 1'b1;
    s1_rready = 1'b0; s0_rready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (m_rready !== 1'b0) begin errors++; $display("FAIL bp_stall_%0d: m_rready got %b want 0", c, m_rready); end
      checks++; if (s1_rvalid !== 1'b1) begin errors++; $display("FAIL bp_rvalid_%0d: got %b want 1", c, s1_rvalid); end
      @(negedge clk);
    end
    s1_rready = 1'b1;
    #1;
    checks++; if (m_rready !== 1'b1) begin errors++; $display("FAIL bp_accept: m_rready got %b want 1", m_rready); end
    checks++; if (s1_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bp_rdata: got %h want deadbeef", s1_rdata); end
    checks++; if (s0_rvalid !== 1'b0) begin errors++; $display("FAIL bp_s0_rvalid: got %b want 0", s0_rvalid); end
    @(negedge clk);
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_len_err;
    int lat, g, n0, n1, rl0, rl1, dbad;
    logic [31:0] addr; logic [7:0] len; logic [2:0] size; bit ar_after, to;
    @(negedge clk);
    #1;
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL lenerr_before: got %b want 0", len_err); end
    s0_araddr = 32'h500; s0_arlen = 8'd3; s0_arvalid = 1'b1;
    @(negedge clk);
    run_burst(0, 1, 1'b1, lat, g, addr, len, size, ar_after, n0, n1, rl0, rl1, dbad, to);
    #1;
    checks++; if (n0 !== 2) begin errors++; $display("FAIL lenerr_beats: got %0d want 2", n0); end
    checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL lenerr_set: got %b want 1", len_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lenerr_idle: got busy %b want 0", busy); end
    s1_araddr = 32'h600; s1_arlen = 8'd0; s1_arvalid = 1'b1;
    @(negedge clk);
    run_burst(0, 0, 1'b1, lat, g, addr, len, size, ar_after, n0, n1, rl0, rl1, dbad, to);
    #1;
    checks++; if (n1 !== 1) begin errors++; $display("FAIL lenerr_clean_beats: got %0d want 1", n1); end
    checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL lenerr_sticky: got %b want 1", len_err); end
  endtask

  task automatic test_reset_mid;
    int lat, g, n0, n1, rl0, rl1, dbad;
    logic [31:0] addr; logic [7:0] len; logic [2:0] size; bit ar_after, to;
    @(negedge clk);
    s0_araddr = 32'h400; s0_arlen = 8'd15; s0_arsize = 3'd2; s0_arvalid = 1'b1;
    wait_arvalid(lat, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL rmid_timeout: m_arvalid never rose"); end
    m_arready = 1'b1;
    @(negedge clk);
    m_arready = 1'b0; s0_arvalid = 1'b0; s0_rready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1'b1; m_rlast = 1'b0; m_rdata = b;
      @(negedge clk);
    end
    m_rvalid = 1'b1;
    #1;
    checks++; if (s0_rvalid !== 1'b1) begin errors++; $display("FAIL rmid_beat5: got %b want 1", s0_rvalid); end
    #1 rst = 1'b0;
    #1;
    checks++; if (m_rready !== 1'b0) begin errors++; $display("FAIL rmid_m_rready: got %b want 0", m_rready); end
    checks++; if (s0_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_s0_rvalid: got %b want 0", s0_rvalid); end
    checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL rmid_m_arvalid: got %b want 0", m_arvalid); end
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL rmid_len_err: got %b want 0", len_err); end
    @(negedge clk);
    rst = 1'b1;
    s0_araddr = 32'h700; s0_arlen = 8'd0; s0_arvalid = 1'b1;
    s1_araddr = 32'h800; s1_arlen = 8'd0; s1_arvalid = 1'b1;
    #1;
    checks++; if (m_rready !== 1'b0) begin errors++; $display("FAIL rmid_idle_rready: got %b want 0", m_rready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_idle_busy: got %b want 0", busy); end
    m_rvalid = 1'b0;
    run_burst(0, 0, 1'b1, lat, g, addr, len, size, ar_after, n0, n1, rl0, rl1, dbad, to);
    s1_arvalid = 1'b0;
    checks++; if (g !== 0) begin errors++; $display("FAIL rmid_tie_grant: got %0d want 0", g); end
    checks++; if (addr !== 32'h700) begin errors++; $display("FAIL rmid_tie_addr: got %h want 700", addr); end
  endtask

  task automatic test_overrun;
    int lat; bit to;
    @(negedge clk);
    s1_araddr = 32'h900; s1_arlen = 8'd1; s1_arvalid = 1'b1;
    wait_arvalid(lat, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL ovr_timeout: m_arvalid never rose"); end
    m_arready = 1'b1;
    @(negedge clk);
    m_arready = 1'b0; s1_arvalid = 1'b0; s1_rready = 1'b1;
    m_rvalid = 1'b1; m_rlast = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL ovr_early: got %b want 0", len_err); end
    @(negedge clk);
    #1;
    checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", len_err); end
    m_rlast = 1'b1;
    @(negedge clk);
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovr_idle: got busy %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_fairness();
    test_backpressure();
    test_len_err();
    test_reset_mid();
    test_overrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
